// File: rtl/me_feeder.sv
// me_feeder: host-side buffer engine for the motion-estimation core.
// The host loads one current block and one reference window while idle.
// A search then serves those words to the core on request. Finally the
// core's MSAD result is captured and handed back to the host.
//
// Handshake semantics (result port): res_valid is raised by the core's
// data_valid strobe and stays high, with res_sad/res_col/res_row stable,
// until the host samples res_valid && res_ready on a rising edge. The
// following cycle res_valid is low. res_ready is ignored while res_valid
// is low.
module me_feeder #(
  parameter int CUR_DEPTH = 64,
  parameter int REF_DEPTH = 288
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_we,
  input  logic        ld_sel,
  input  logic [63:0] ld_data,
  output logic        ld_ready,
  input  logic        start,
  output logic        busy,
  output logic        en_i,
  output logic [31:0] cur_in_i,
  output logic [63:0] ref_in_i,
  input  logic        cur_read_en,
  input  logic        ref_read_en,
  input  logic [13:0] MSAD,
  input  logic [4:0]  MSAD_column,
  input  logic [4:0]  MSAD_row,
  input  logic        data_valid,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [13:0] res_sad,
  output logic [4:0]  res_col,
  output logic [4:0]  res_row,
  output logic        underrun
);

  // Counts and pointers must be able to hold the full depth.
  localparam int CW = $clog2(CUR_DEPTH + 1);
  localparam int RW = $clog2(REF_DEPTH + 1);
  // Memory address widths; counts only index memory when below depth.
  localparam int CA = (CUR_DEPTH > 1) ? $clog2(CUR_DEPTH) : 1;
  localparam int RA = (REF_DEPTH > 1) ? $clog2(REF_DEPTH) : 1;

  localparam logic [CW-1:0] CUR_FULL = CW'(CUR_DEPTH);
  localparam logic [CW-1:0] CUR_LAST = CW'(CUR_DEPTH - 1);
  localparam logic [RW-1:0] REF_FULL = RW'(REF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]   cur_mem [CUR_DEPTH];
  logic [63:0]   ref_mem [REF_DEPTH];
  logic [CW-1:0] wr_cur;
  logic [RW-1:0] wr_ref;
  logic [CW-1:0] rd_cur;
  logic [RW-1:0] rd_ref;

  logic go;
  logic handshake;
  logic cur_we;
  logic ref_we;

  // A search may only begin once both buffers are completely loaded;
  // the counts seen here are the ones before any same-cycle write.
  assign go        = (state == S_IDLE) && start &&
                     (wr_cur == CUR_FULL) && (wr_ref == REF_FULL);
  assign handshake = (state == S_DONE) && res_valid && res_ready;
  assign cur_we    = (state == S_IDLE) && ld_we && !ld_sel && (wr_cur != CUR_FULL);
  assign ref_we    = (state == S_IDLE) && ld_we &&  ld_sel && (wr_ref != REF_FULL);

  assign ld_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state decode: IDLE -> RUN on a valid start, RUN -> DONE on the
  // core result, DONE -> IDLE once the host has taken the result.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (go)          state_next = S_RUN;
      S_RUN:   if (data_valid)  state_next = S_DONE;
      S_DONE:  if (handshake)   state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
  end

  // Buffer storage; contents survive searches and are simply overwritten.
  always_ff @(posedge clk) begin
    if (cur_we) cur_mem[wr_cur[CA-1:0]] <= ld_data[31:0];
    if (ref_we) ref_mem[wr_ref[RA-1:0]] <= ld_data;
  end

  // Write counts saturate at depth and are cleared once a result is
  // returned, forcing a reload before the next search.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cur <= '0;
      wr_ref <= '0;
    end else if (handshake) begin
      wr_cur <= '0;
      wr_ref <= '0;
    end else begin
      if (cur_we) wr_cur <= wr_cur + CW'(1);
      if (ref_we) wr_ref <= wr_ref + RW'(1);
    end
  end

  // Read service: the current block wraps for re-scans, the reference
  // window does not, and reading past its end flags a sticky underrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cur   <= '0;
      rd_ref   <= '0;
      cur_in_i <= '0;
      ref_in_i <= '0;
      underrun <= 1'b0;
    end else if (go) begin
      rd_cur   <= '0;
      rd_ref   <= '0;
      underrun <= 1'b0;
    end else if (state == S_RUN) begin
      if (cur_read_en) begin
        cur_in_i <= cur_mem[rd_cur[CA-1:0]];
        rd_cur   <= (rd_cur == CUR_LAST) ? '0 : rd_cur + CW'(1);
      end
      if (ref_read_en) begin
        if (rd_ref == REF_FULL) begin
          underrun <= 1'b1;
        end else begin
          ref_in_i <= ref_mem[rd_ref[RA-1:0]];
          rd_ref   <= rd_ref + RW'(1);
        end
      end
    end
  end

  // Core enable and result capture/return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_i      <= 1'b0;
      res_valid <= 1'b0;
      res_sad   <= '0;
      res_col   <= '0;
      res_row   <= '0;
    end else begin
      if (go) en_i <= 1'b1;
      if ((state == S_RUN) && data_valid) begin
        en_i      <= 1'b0;
        res_valid <= 1'b1;
        res_sad   <= MSAD;
        res_col   <= MSAD_column;
        res_row   <= MSAD_row;
      end
      if (handshake) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_me_feeder.sv
// tb_me_feeder: self-checking bench for me_feeder with a behavioural
// model of the buffers (plain arrays indexed by request number).
module tb_me_feeder;
  localparam int CD = 64;
  localparam int RD = 288;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ld_we, ld_sel, start;
  logic [63:0] ld_data;
  logic        ld_ready, busy, en_i;
  logic [31:0] cur_in_i;
  logic [63:0] ref_in_i;
  logic        cur_read_en, ref_read_en;
  logic [13:0] msad;
  logic [4:0]  msad_column, msad_row;
  logic        data_valid;
  logic        res_valid, res_ready;
  logic [13:0] res_sad;
  logic [4:0]  res_col, res_row;
  logic        underrun;

  me_feeder #(.CUR_DEPTH(CD), .REF_DEPTH(RD)) dut (
    .clk(clk), .rst(rst),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .busy(busy), .en_i(en_i),
    .cur_in_i(cur_in_i), .ref_in_i(ref_in_i),
    .cur_read_en(cur_read_en), .ref_read_en(ref_read_en),
    .MSAD(msad), .MSAD_column(msad_column), .MSAD_row(msad_row),
    .data_valid(data_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sad(res_sad), .res_col(res_col), .res_row(res_row),
    .underrun(underrun)
  );

  // ---------------- model / scoreboard ----------------
  logic [31:0] cur_m [CD];
  logic [63:0] ref_m [RD];
  logic [31:0] cur_exp;
  logic [63:0] ref_exp;
  logic [23:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic sel, input logic [63:0] d);
    ld_we = 1'b1; ld_sel = sel; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  // mode 0: index pattern, mode 1: random data.
  task automatic load_all(input int mode, input int n_cur);
    logic [63:0] d;
    for (int i = 0; i < n_cur; i++) begin
      d = (mode == 0) ? 64'(i) : {$urandom, $urandom};
      cur_m[i] = d[31:0];
      write_word(1'b0, d);
    end
    for (int i = 0; i < RD; i++) begin
      d = (mode == 0) ? (64'(i) << 8) : {$urandom, $urandom};
      ref_m[i] = d;
      write_word(1'b1, d);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},  64'(en_i), 64'(0));
    check({tag, "_cur"}, 64'(cur_in_i), 64'(0));
    check({tag, "_ref"}, ref_in_i, 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_ldrdy"}, 64'(ld_ready), 64'(1));
    check({tag, "_rv"},  64'(res_valid), 64'(0));
    check({tag, "_res"}, 64'({res_sad, res_col, res_row}), 64'(0));
    check({tag, "_und"}, 64'(underrun), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] d;
    logic [23:0] r;
    int ci, ri;
    logic und_exp;

    rst = 1'b0; ld_we = 0; ld_sel = 0; ld_data = '0; start = 0;
    cur_read_en = 0; ref_read_en = 0; msad = '0; msad_column = '0;
    msad_row = '0; data_valid = 0; res_ready = 0;
    tick(); tick();
    check_reset_outputs("rst0");
    rst = 1'b1;
    tick();

    // Index-pattern load and start.
    load_all(0, CD);
    pulse_start();
    check("start_en", 64'(en_i), 64'(1));
    check("start_busy", 64'(busy), 64'(1));
    check("start_ldrdy", 64'(ld_ready), 64'(0));

    // 66 back-to-back current reads wrap the block.
    cur_read_en = 1'b1;
    for (int i = 0; i < 66; i++) begin
      tick();
      cur_exp = cur_m[i % CD];
      check($sformatf("cur_rd%0d", i), 64'(cur_in_i), 64'(cur_exp));
    end
    cur_read_en = 1'b0;

    // 289 reference reads: the last one underruns and holds data.
    ref_read_en = 1'b1;
    for (int i = 0; i <= RD; i++) begin
      tick();
      ref_exp = (i < RD) ? ref_m[i] : ref_m[RD-1];
      check($sformatf("ref_rd%0d", i), ref_in_i, ref_exp);
      check($sformatf("und%0d", i), 64'(underrun), 64'(i >= RD));
    end
    ref_read_en = 1'b0;

    // Result held while the host stalls.
    msad = 14'h1ABC; msad_column = 5'd17; msad_row = 5'd5; data_valid = 1'b1;
    exp_q.push_back({14'h1ABC, 5'd17, 5'd5});
    tick();
    data_valid = 1'b0; msad = '0; msad_column = '0; msad_row = '0;
    r = exp_q.pop_front();
    check("dv_en", 64'(en_i), 64'(0));
    for (int i = 0; i < 10; i++) begin
      cur_read_en = 1'($urandom_range(0, 1));
      ref_read_en = 1'($urandom_range(0, 1));
      check("done_rv", 64'(res_valid), 64'(1));
      check("done_res", 64'({res_sad, res_col, res_row}), 64'(r));
      check("done_busy", 64'(busy), 64'(1));
      tick();
      check("done_cur_hold", 64'(cur_in_i), 64'(cur_exp));
      check("done_ref_hold", ref_in_i, ref_exp);
    end
    cur_read_en = 0; ref_read_en = 0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hs_rv", 64'(res_valid), 64'(0));
    check("hs_ldrdy", 64'(ld_ready), 64'(1));
    check("hs_und_hold", 64'(underrun), 64'(1));

    // Counts were cleared by the handshake: start is refused.
    pulse_start();
    check("noload_en", 64'(en_i), 64'(0));

    // 63 current words: start ignored; collision write + start ignored.
    load_all(1, CD - 1);
    pulse_start();
    check("short_en", 64'(en_i), 64'(0));
    check("short_busy", 64'(busy), 64'(0));
    d = {$urandom, $urandom};
    cur_m[CD-1] = d[31:0];
    ld_we = 1'b1; ld_sel = 1'b0; ld_data = d; start = 1'b1;
    tick();
    ld_we = 1'b0; start = 1'b0;
    check("coll_en", 64'(en_i), 64'(0));
    check("coll_ldrdy", 64'(ld_ready), 64'(1));
    // Writes to full buffers are dropped.
    write_word(1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
    write_word(1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    pulse_start();
    check("run2_en", 64'(en_i), 64'(1));
    check("run2_und_clr", 64'(underrun), 64'(0));

    // Randomized reads against the array model.
    ci = 0; ri = 0; und_exp = 1'b0;
    for (int n = 0; n < 300; n++) begin
      cur_read_en = 1'($urandom_range(0, 1));
      ref_read_en = ($urandom_range(0, 3) == 0);
      res_ready   = 1'($urandom_range(0, 1));
      if (cur_read_en) begin cur_exp = cur_m[ci % CD]; ci++; end
      if (ref_read_en) begin
        if (ri < RD) begin ref_exp = ref_m[ri]; ri++; end
        else und_exp = 1'b1;
      end
      tick();
      check("rnd_cur", 64'(cur_in_i), 64'(cur_exp));
      check("rnd_ref", ref_in_i, ref_exp);
      check("rnd_und", 64'(underrun), 64'(und_exp));
      check("rnd_rv", 64'(res_valid), 64'(0));
    end
    res_ready = 1'b0;

    // Result strobe with a same-cycle current read.
    r = 24'($urandom);
    exp_q.push_back(r);
    {msad, msad_column, msad_row} = r;
    data_valid = 1'b1; cur_read_en = 1'b1; ref_read_en = 1'b0;
    cur_exp = cur_m[ci % CD]; ci++;
    tick();
    data_valid = 1'b0; cur_read_en = 1'b0;
    check("dv2_cur", 64'(cur_in_i), 64'(cur_exp));
    check("dv2_rv", 64'(res_valid), 64'(1));
    check("dv2_res", 64'({res_sad, res_col, res_row}), 64'(exp_q.pop_front()));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hs2_rv", 64'(res_valid), 64'(0));
    check("hs2_busy", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of a search.
    load_all(0, CD);
    pulse_start();
    cur_read_en = 1'b1; ref_read_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    cur_read_en = 1'b0; ref_read_en = 1'b0;
    check("pre_rst_cur", 64'(cur_in_i), 64'(cur_m[9]));
    rst = 1'b0;
    #1;
    check_reset_outputs("rst1");
    tick();
    rst = 1'b1;
    tick();
    load_all(1, CD);
    pulse_start();
    check("run3_en", 64'(en_i), 64'(1));
    cur_read_en = 1'b1; ref_read_en = 1'b1;
    tick();
    cur_read_en = 1'b0; ref_read_en = 1'b0;
    check("run3_cur0", 64'(cur_in_i), 64'(cur_m[0]));
    check("run3_ref0", ref_in_i, ref_m[0]);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
